// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb engine / blast resolver pair: map codes,
// grid geometry, game result encoding and small helpers used by both sides.
package bomb_pkg;

  localparam int GRID_W = 16;
  localparam int GRID_N = 256;

  localparam logic [2:0] EMPTY_WALL = 3'd0;
  localparam logic [2:0] HARD_WALL  = 3'd1;
  localparam logic [2:0] SOFT_WALL  = 3'd2;
  localparam logic [2:0] ITEM_LEN   = 3'd3;

  typedef enum logic [1:0] {
    TILE_IDLE  = 2'd0,
    TILE_BOMB  = 2'd1,
    TILE_BLAST = 2'd2
  } tile_state_e;

  typedef enum logic [1:0] {
    GS_PLAY   = 2'd0,
    GS_P1_WIN = 2'd1,
    GS_P2_WIN = 2'd2,
    GS_DRAW   = 2'd3
  } game_state_e;

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_e;

  // Start-of-game map: pillar lattice, cleared spawn corners, soft walls elsewhere.
  function automatic logic [2:0] reset_code(input logic [7:0] tile);
    logic [3:0] row;
    logic [3:0] col;
    row = 4'(int'(tile) / GRID_W);
    col = 4'(int'(tile) % GRID_W);
    if (row[0] && col[0]) return HARD_WALL;
    if (tile == 8'd0 || tile == 8'd1 || tile == 8'd16 ||
        tile == 8'd239 || tile == 8'd254 || tile == 8'd255) return EMPTY_WALL;
    return SOFT_WALL;
  endfunction

  // 8-bit Fibonacci LFSR, taps 8,6,5,4.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/player_life.sv
// Per-player life counter: takes a hit when standing in a blast, then ignores
// further blasts for an invulnerability window.
module player_life
  import bomb_pkg::*;
#(
  parameter int         INV_CYCLES  = 90,
  parameter logic [1:0] START_LIVES = 2'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       explode_at_cor,
  input  logic       enable,
  output logic [1:0] lives,
  output logic       hit
);

  localparam int INV_W = $clog2(INV_CYCLES + 1);

  logic [INV_W-1:0] inv_ctr;

  always_ff @(posedge clk) begin
    if (reset) begin
      lives   <= START_LIVES;
      hit     <= 1'b0;
      inv_ctr <= '0;
    end else begin
      hit <= 1'b0;
      if (explode_at_cor && inv_ctr == '0 && lives != 2'd0 && enable) begin
        lives   <= lives - 2'd1;
        hit     <= 1'b1;
        inv_ctr <= INV_W'(INV_CYCLES);
      end else if (inv_ctr != '0) begin
        inv_ctr <= inv_ctr - INV_W'(1);
      end
    end
  end

endmodule

// File: rtl/blast_resolver.sv
// Map owner downstream of the bomb engine: latches blast edges, sweeps the grid
// one tile per cycle to destroy walls / drop items, applies pickups, tracks lives.
module blast_resolver
  import bomb_pkg::*;
#(
  parameter int         INV_CYCLES  = 90,
  parameter logic [1:0] START_LIVES = 2'd3,
  parameter logic [7:0] LFSR_SEED   = 8'hA5,
  parameter logic [7:0] DROP_MASK   = 8'h03
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] explode,
  input  logic [7:0]   p1_cor,
  input  logic [7:0]   p2_cor,
  output logic [2:0]   wall_grid [0:GRID_N-1],
  output logic [1:0]   p1_bomb_len,
  output logic [1:0]   p2_bomb_len,
  output logic [1:0]   p1_lives,
  output logic [1:0]   p2_lives,
  output logic         p1_hit,
  output logic         p2_hit,
  output logic [1:0]   game_state,
  output logic         busy
);

  scan_state_e  state;
  game_state_e  gs;
  logic [7:0]   idx;
  logic [7:0]   lfsr;
  logic [255:0] pending;
  logic [255:0] explode_prev;
  logic [255:0] rise;
  logic [255:0] clr;
  logic         scan_hit;
  logic [2:0]   scan_code;
  logic         pick1;
  logic         pick2;

  assign game_state = gs;

  // Edge history runs through reset so a blast held across reset is not a new edge.
  always_ff @(posedge clk) begin
    explode_prev <= explode;
  end

  always_comb begin
    rise      = explode & ~explode_prev;
    scan_hit  = (state == SCAN_RUN) && pending[idx];
    clr       = '0;
    clr[idx]  = scan_hit;
    scan_code = wall_grid[idx];
    case (wall_grid[idx])
      SOFT_WALL: scan_code = ((lfsr & DROP_MASK) == 8'd0) ? ITEM_LEN : EMPTY_WALL;
      ITEM_LEN:  scan_code = EMPTY_WALL;
      default:   scan_code = wall_grid[idx];
    endcase
    // A scan write to the same tile beats a pickup; P1 beats P2 on a shared tile.
    pick1 = (wall_grid[p1_cor] == ITEM_LEN) && !(scan_hit && idx == p1_cor);
    pick2 = (wall_grid[p2_cor] == ITEM_LEN) && !(scan_hit && idx == p2_cor) &&
            !(pick1 && p2_cor == p1_cor);
  end

  // Scan FSM: state is visible on busy (1 while sweeping).
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SCAN_IDLE;
      idx     <= 8'd0;
      busy    <= 1'b0;
      pending <= '0;
      lfsr    <= LFSR_SEED;
    end else begin
      // New edges are OR'd after the clear so a same-cycle re-trigger survives.
      pending <= (pending & ~clr) | rise;
      if (scan_hit && wall_grid[idx] == SOFT_WALL) lfsr <= lfsr_next(lfsr);
      case (state)
        SCAN_IDLE: begin
          if (|pending) begin
            state <= SCAN_RUN;
            idx   <= 8'd0;
            busy  <= 1'b1;
          end
        end
        SCAN_RUN: begin
          if (idx == 8'd255) begin
            state <= SCAN_IDLE;
            busy  <= 1'b0;
          end else begin
            idx <= idx + 8'd1;
          end
        end
        default: begin
          state <= SCAN_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < GRID_N; i++) wall_grid[i] <= reset_code(8'(i));
    end else begin
      if (pick1) wall_grid[p1_cor] <= EMPTY_WALL;
      if (pick2) wall_grid[p2_cor] <= EMPTY_WALL;
      if (scan_hit) wall_grid[idx] <= scan_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p1_bomb_len <= 2'd0;
      p2_bomb_len <= 2'd0;
    end else begin
      if (pick1 && p1_bomb_len != 2'd3) p1_bomb_len <= p1_bomb_len + 2'd1;
      if (pick2 && p2_bomb_len != 2'd3) p2_bomb_len <= p2_bomb_len + 2'd1;
    end
  end

  player_life #(.INV_CYCLES(INV_CYCLES), .START_LIVES(START_LIVES)) u_life1 (
    .clk            (clk),
    .reset          (reset),
    .explode_at_cor (explode[p1_cor]),
    .enable         (gs == GS_PLAY),
    .lives          (p1_lives),
    .hit            (p1_hit)
  );

  player_life #(.INV_CYCLES(INV_CYCLES), .START_LIVES(START_LIVES)) u_life2 (
    .clk            (clk),
    .reset          (reset),
    .explode_at_cor (explode[p2_cor]),
    .enable         (gs == GS_PLAY),
    .lives          (p2_lives),
    .hit            (p2_hit)
  );

  // Result follows the lives registers by one cycle and then holds until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      gs <= GS_PLAY;
    end else if (gs == GS_PLAY) begin
      if (p1_lives == 2'd0 && p2_lives == 2'd0) gs <= GS_DRAW;
      else if (p1_lives == 2'd0)                gs <= GS_P2_WIN;
      else if (p2_lives == 2'd0)                gs <= GS_P1_WIN;
    end
  end

endmodule
